// File: rtl/reg5_write_ctrl.sv
// reg5_write_ctrl: control stage in front of four 5-bit loadable registers.
// It accepts one instruction per handshake, reads the operands back from
// rd_data, computes a 5-bit result and drives Din together with a one-cycle
// one-hot sel pulse. Each instruction takes three cycles:
// IDLE (handshake) -> DECODE (operand read and compute) -> EXEC (write pulse).
// Optional build macro: SAT_ADD_EN. When defined, ADD saturates to 5'b11111
// on overflow instead of wrapping. carry reports the overflow in both builds.
module reg5_write_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [10:0] instr,
    input  logic [19:0] rd_data,
    output logic [4:0]  Din,
    output logic [3:0]  sel,
    output logic        busy,
    output logic        carry
);

    localparam int NREG = 4;
    localparam int W    = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_MOVE = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    // Pick register idx out of the concatenated Dout bus.
    function automatic logic [W-1:0] reg_word(input logic [NREG*W-1:0] bus,
                                              input logic [1:0] idx);
        case (idx)
            2'd0:    reg_word = bus[4:0];
            2'd1:    reg_word = bus[9:5];
            2'd2:    reg_word = bus[14:10];
            2'd3:    reg_word = bus[19:15];
            default: reg_word = 5'd0;
        endcase
    endfunction

    // One-hot select for a 2-bit register index.
    function automatic logic [NREG-1:0] onehot(input logic [1:0] idx);
        case (idx)
            2'd0:    onehot = 4'b0001;
            2'd1:    onehot = 4'b0010;
            2'd2:    onehot = 4'b0100;
            2'd3:    onehot = 4'b1000;
            default: onehot = 4'b0000;
        endcase
    endfunction

    state_t         state_r;
    state_t         state_next_s;
    logic [1:0]     op_r;
    logic [1:0]     dst_r;
    logic [1:0]     src_r;
    logic [W-1:0]   imm_r;
    logic [W-1:0]   din_r;
    logic [NREG-1:0] sel_r;
    logic           ready_r;
    logic           busy_r;
    logic           carry_r;

    logic           xfer_s;
    logic [W-1:0]   dst_val_s;
    logic [W-1:0]   src_val_s;
    logic [W:0]     sum_s;
    logic [W-1:0]   result_s;

    assign xfer_s      = instr_valid & ready_r;
    assign instr_ready = ready_r;
    assign busy        = busy_r;
    assign Din         = din_r;
    assign sel         = sel_r;
    assign carry       = carry_r;

    // Next-state logic for the three-phase instruction sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (xfer_s) begin
                    state_next_s = ST_DECODE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DECODE: state_next_s = ST_EXEC;
            ST_EXEC:   state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // Operand read and result computation, used on the DECODE -> EXEC edge.
    always_comb begin
        dst_val_s = reg_word(rd_data, dst_r);
        src_val_s = reg_word(rd_data, src_r);
        sum_s     = {1'b0, dst_val_s} + {1'b0, src_val_s};
        result_s  = din_r;
        case (op_r)
            OP_LOAD: result_s = imm_r;
            OP_MOVE: result_s = src_val_s;
            OP_ADD: begin
`ifdef SAT_ADD_EN
                if (sum_s[W]) begin
                    result_s = 5'b11111;
                end else begin
                    result_s = sum_s[W-1:0];
                end
`else
                result_s = sum_s[W-1:0];
`endif
            end
            OP_NOP:  result_s = din_r;
            default: result_s = din_r;
        endcase
    end

    // State register and all registered outputs; reset drops sel at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            op_r    <= 2'd0;
            dst_r   <= 2'd0;
            src_r   <= 2'd0;
            imm_r   <= 5'd0;
            din_r   <= 5'd0;
            sel_r   <= 4'd0;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            carry_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            case (state_r)
                ST_IDLE: begin
                    sel_r <= 4'd0;
                    if (xfer_s) begin
                        op_r    <= instr[10:9];
                        dst_r   <= instr[8:7];
                        src_r   <= instr[6:5];
                        imm_r   <= instr[4:0];
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (op_r != OP_NOP) begin
                        din_r <= result_s;
                        sel_r <= onehot(dst_r);
                    end else begin
                        sel_r <= 4'd0;
                    end
                    if (op_r == OP_ADD) begin
                        carry_r <= sum_s[W];
                    end
                end
                ST_EXEC: begin
                    sel_r   <= 4'd0;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
                default: begin
                    sel_r   <= 4'd0;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule
